// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter sequencing writes from NUM_REQ requesters into one
// shared WIDTH-bit register. Each write is a one-cycle GRANT followed by a
// HOLD window of HOLD_CYCLES cycles; ack marks the first HOLD cycle.
module dff_reg_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   d_flat,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         ack,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [3:0]    hold_cnt;

    logic [IW-1:0] winner;
    logic          found;
    int            scan_idx;

    // Pick the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && req[IW'(scan_idx)]) begin
                found  = 1'b1;
                winner = IW'(scan_idx);
            end
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: all state, including the shared data register, is cleared by reset.
            state    <= S_IDLE;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            ack      <= '0;
            q        <= '0;
            owner    <= '0;
            busy     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                S_IDLE: begin
                    ack <= '0;
                    if (found) begin
                        gnt   <= NUM_REQ'(1) << winner;
                        owner <= winner;
                        busy  <= 1'b1;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    gnt <= '0;
                    if (req[owner]) begin
                        q        <= d_flat[int'(owner)*WIDTH +: WIDTH];
                        rr_ptr   <= (owner == IW'(NUM_REQ-1)) ? '0 : owner + IW'(1);
                        ack      <= NUM_REQ'(1) << owner;
                        hold_cnt <= 4'(HOLD_CYCLES-1);
                        state    <= S_HOLD;
                    end else begin
                        // Requester withdrew during its grant: abandon the write.
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    ack <= '0;
                    if (hold_cnt == 4'd0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dff_reg_arbiter.md
Name: dff_reg_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit storage register, built from D flip-flops, among NUM_REQ requesters. A requester raises req and receives a one-cycle grant, during which it presents data. The register loads that data and the winner gets a one-cycle ack. A programmable hold window follows each write before the next arbitration. The block sits between the requester ports and the register bank, sequencing every write into it.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, register width in bits
HOLD_CYCLES, 2, cycles spent in HOLD after each write (1..15); ack occupies the first HOLD cycle

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
req  input  NUM_REQ  per-requester request, level, held until ack
d_flat  input  NUM_REQ*WIDTH  requester data; requester i uses bits [i*WIDTH +: WIDTH]
gnt  output  NUM_REQ  one-hot grant, high only in the GRANT state
ack  output  NUM_REQ  one-hot one-cycle write acknowledge
q  output  WIDTH  shared register contents
owner  output  $clog2(NUM_REQ)  index of the last granted requester
busy  output  1  high in GRANT and HOLD

Behaviour:
- All outputs are registered. Reset is synchronous and takes priority over everything, including mid-operation: q=0, gnt=0, ack=0, owner=0, busy=0, state=IDLE, rr_ptr=0.
- FSM states: IDLE, GRANT, HOLD.
- IDLE with no req bits set: stay in IDLE; all outputs hold their values (gnt/ack stay 0).
- IDLE with any req bit set:
  - winner = first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Next cycle: state=GRANT, gnt[winner]=1, owner=winner, busy=1.
- GRANT, always 1 cycle. The requester must present data on its d_flat slice during this cycle.
  - If req[winner]=1: at the closing edge, q <= winner's slice, rr_ptr <= (winner+1) mod NUM_REQ, gnt <= 0, ack[winner] <= 1, state <= HOLD, hold counter loaded.
  - If req[winner]=0 (abort): q unchanged, no ack, rr_ptr unchanged, gnt <= 0, busy <= 0, state <= IDLE. owner keeps winner.
- HOLD: lasts exactly HOLD_CYCLES cycles, then IDLE.
  - ack is high only in the first HOLD cycle.
  - busy=1 throughout; gnt=0.
  - req changes are ignored.
  - On return to IDLE, busy <= 0.
- Latency: req sampled high at edge k (IDLE) -> gnt high in cycle k+1 -> q and ack valid in cycle k+2.
  - Minimum spacing between consecutive grants is 2+HOLD_CYCLES cycles.
  - A requester keeping req high through ack is re-arbitrated normally; round-robin guarantees each of N continuous requesters one write per N grants.
- q changes only on a successful GRANT edge or on reset; it holds otherwise.
- Out-of-range d_flat bits of non-winners have no effect.

Test Plan:
1. Reset, then req=0000 for 10 cycles -> q=0x00, gnt=0, ack=0, busy=0 throughout.
2. req=0100 with slice2=0xA5 -> gnt=0100 one cycle later; next cycle q=0xA5, ack=0100 for exactly one cycle; busy high for 1+HOLD_CYCLES=3 cycles.
3. req=1111 held, slices 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0; q sequence 0x11, 0x22, 0x33, 0x44, 0x11; grants 4 cycles apart.
4. After a requester-1 win, req=0011 -> requester 0 granted before requester 1 again (rr_ptr=2 wraps to 0).
5. req[3] dropped during its GRANT cycle -> no ack, q keeps its previous value, busy low next cycle; requester 3 still wins the next arbitration if it re-requests first.
6. reset asserted during GRANT and again during HOLD -> next cycle q=0, gnt=0, ack=0, owner=0, busy=0; a subsequent req=1000 is granted normally.
